// File: rtl/mssd_pkg.sv
// mssd_pkg
// Shared types and default parameters for the parametrised serial
// stream demultiplexer (mssd_demux_p) and its length counter.
//   mssd_state_t : receiver FSM states
//   N_CH_DEF     : default number of output channels
//   CNT_W_DEF    : default width of the payload length field
package mssd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        LOAD,
        PAYLOAD,
        PARITY,
        STOP,
        ERR
    } mssd_state_t;

    localparam int N_CH_DEF  = 4;
    localparam int CNT_W_DEF = 6;

endpackage

// File: rtl/mssd_len_cnt.sv
// mssd_len_cnt
// Loadable down-counter holding the number of payload bits still to come.
// It stops at zero rather than wrapping.
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-low reset (count cleared)
//   ld   : load din into the counter (has priority over en)
//   en   : decrement by one
//   din  : load value
//   last : count == 1 (current payload bit is the final one)
//   zero : count == 0
module mssd_len_cnt #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic             en,
    input  logic [CNT_W-1:0] din,
    output logic             last,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    // Load wins over decrement; the count holds at zero so it never wraps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (ld) begin
            cnt <= din;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign last = (cnt == CNT_W'(1));
    assign zero = (cnt == '0);

endmodule

// File: rtl/mssd_demux_p.sv
// mssd_demux_p
// Parametrised serial-to-multichannel stream demultiplexer.
// Frame on sIn: start bit (0), header (address then length, LSB first),
// payload bits, optional even-parity bit, stop bit (1).
// Optional feature macro: MSSD_PARITY_EN (adds the parity bit and check).
// Ports:
//   clk        : system clock
//   rst        : asynchronous active-low reset
//   sIn        : serial data, idles high
//   outValid   : high on every payload-bit cycle
//   Error      : high while in the error state
//   frame_done : one-cycle pulse when a good stop bit is accepted
//   busy       : high while a frame is being received
//   d          : latched channel address, 0 outside a frame
//   p          : per-channel data, p[d] = sIn during payload, else 0
module mssd_demux_p
    import mssd_pkg::*;
#(
    parameter int N_CH   = N_CH_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    localparam int ADDR_W = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sIn,
    output logic              outValid,
    output logic              Error,
    output logic              frame_done,
    output logic              busy,
    output logic [ADDR_W-1:0] d,
    output logic [N_CH-1:0]   p
);

    localparam int H    = ADDR_W + CNT_W;
    localparam int HC_W = $clog2(H);

    mssd_state_t       state;
    mssd_state_t       stateNext;
    logic [H-1:0]      hdr;
    logic [HC_W-1:0]   hcnt;
    logic [CNT_W-1:0]  hdrLen;
    logic [ADDR_W-1:0] hdrAddr;
    logic              lenLd;
    logic              lenEn;
    logic              lenLast;
    logic              lenZero;
`ifdef MSSD_PARITY_EN
    logic              parAcc;
`endif

    assign hdrAddr = hdr[ADDR_W-1:0];
    assign hdrLen  = hdr[H-1:ADDR_W];
    assign lenLd   = (state == LOAD);
    assign lenEn   = (state == PAYLOAD);

    mssd_len_cnt #(
        .CNT_W (CNT_W)
    ) u_len_cnt (
        .clk  (clk),
        .rst  (rst),
        .ld   (lenLd),
        .en   (lenEn),
        .din  (hdrLen),
        .last (lenLast),
        .zero (lenZero)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic. A zero stop bit goes to ERR rather than being taken
    // as the start of a new frame.
    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE:    if (!sIn) stateNext = HDR;
            HDR:     if (hcnt == HC_W'(H-1)) stateNext = LOAD;
`ifdef MSSD_PARITY_EN
            LOAD:    stateNext = (hdrLen == '0) ? PARITY : PAYLOAD;
            PAYLOAD: if (lenLast || lenZero) stateNext = PARITY;
            PARITY:  stateNext = (sIn == parAcc) ? STOP : ERR;
`else
            LOAD:    stateNext = (hdrLen == '0) ? STOP : PAYLOAD;
            PAYLOAD: if (lenLast || lenZero) stateNext = STOP;
`endif
            STOP:    stateNext = sIn ? IDLE : ERR;
            ERR:     if (sIn) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Header shift register and header bit counter. New bits enter at the
    // MSB so the first bit received ends up in bit 0. The counter saturates
    // at H-1 and is only cleared in IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hdr  <= '0;
            hcnt <= '0;
        end else begin
            if (state == HDR) begin
                hdr <= {sIn, hdr[H-1:1]};
                if (hcnt != HC_W'(H-1)) begin
                    hcnt <= hcnt + 1'b1;
                end
            end else if (state == IDLE) begin
                hcnt <= '0;
            end
        end
    end

    // Channel address: captured in LOAD, returned to 0 when the frame ends
    // either normally or through the error state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d <= '0;
        end else if (state == LOAD) begin
            d <= hdrAddr;
        end else if ((stateNext == IDLE) || (stateNext == ERR)) begin
            d <= '0;
        end
    end

`ifdef MSSD_PARITY_EN
    // Running XOR of the payload bits; the parity bit must equal it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            parAcc <= 1'b0;
        end else if (state == LOAD) begin
            parAcc <= 1'b0;
        end else if (state == PAYLOAD) begin
            parAcc <= parAcc ^ sIn;
        end
    end
`endif

    assign outValid   = (state == PAYLOAD);
    assign Error      = (state == ERR);
    assign frame_done = (state == STOP) && sIn;
    assign busy       = (state != IDLE) && (state != ERR);

    // Payload bit steered combinationally onto the addressed channel.
    always_comb begin
        p = '0;
        if (outValid) begin
            p[d] = sIn;
        end
    end

endmodule

// File: tb/tb_mssd_demux_p.sv
// tb_mssd_demux_p
// Self-checking bench for mssd_demux_p (N_CH=4, CNT_W=6, header 8 bits).
// Frames are described by their fields; the expected outputs for every
// cycle follow from the position of that cycle inside the frame.
// Honours MSSD_PARITY_EN the same way as the design.
module tb_mssd_demux_p;

    localparam int N_CH   = 4;
    localparam int CNT_W  = 6;
    localparam int ADDR_W = 2;
    localparam int H      = ADDR_W + CNT_W;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              sIn = 1'b1;
    logic              outValid;
    logic              Error;
    logic              frame_done;
    logic              busy;
    logic [ADDR_W-1:0] d;
    logic [N_CH-1:0]   p;

    logic              chkEn = 1'b0;
    logic              expValid = 1'b0;
    logic              expErr = 1'b0;
    logic              expDone = 1'b0;
    logic              expBusy = 1'b0;
    logic [ADDR_W-1:0] expD = '0;
    logic [N_CH-1:0]   expP = '0;

    int                nCompared = 0;
    int                nMismatched = 0;

    int                validCnt [N_CH];
    int                doneCnt = 0;
    int                capCh = 2;
    logic [62:0]       cap = '0;

    mssd_demux_p #(
        .N_CH  (N_CH),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sIn        (sIn),
        .outValid   (outValid),
        .Error      (Error),
        .frame_done (frame_done),
        .busy       (busy),
        .d          (d),
        .p          (p)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < N_CH; i++) validCnt[i] = 0;
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: every cycle, mid-period, against the frame model.
    always @(negedge clk) begin
        if (chkEn) begin
            checkOutput("outValid", 64'(outValid), 64'(expValid));
            checkOutput("Error", 64'(Error), 64'(expErr));
            checkOutput("frame_done", 64'(frame_done), 64'(expDone));
            checkOutput("busy", 64'(busy), 64'(expBusy));
            checkOutput("d", 64'(d), 64'(expD));
            checkOutput("p", 64'(p), 64'(expP));
        end
        if (outValid) begin
            validCnt[d] <= validCnt[d] + 1;
            cap <= {cap[61:0], p[capCh]};
        end
        if (frame_done) doneCnt <= doneCnt + 1;
    end

    // One clock cycle: drive sIn just after the edge and state what the
    // outputs must be during this cycle.
    task automatic applyStimulus(input logic s, input logic ev, input logic [N_CH-1:0] ep,
                                 input logic [ADDR_W-1:0] ed, input logic ee,
                                 input logic efd, input logic eb);
        @(posedge clk);
        #1;
        sIn      = s;
        expValid = ev;
        expP     = ep;
        expD     = ed;
        expErr   = ee;
        expDone  = efd;
        expBusy  = eb;
    endtask

    task automatic idleBits(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    function automatic logic evenPar(input logic [62:0] pl, input int len);
        logic x = 1'b0;
        for (int i = 0; i < len; i++) x ^= pl[i];
        return x;
    endfunction

    // Start, header, load, payload and (optional) parity and stop cycles.
    // errd reports that the frame must end in the error state.
    task automatic sendFrame(input logic [ADDR_W-1:0] addr, input int len, input logic [62:0] pl,
                             input logic par, input logic stop, output logic errd);
        logic [H-1:0] hb;
        hb   = {CNT_W'(len), addr};
        errd = 1'b0;
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < H; i++) applyStimulus(hb[i], 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < len; i++)
            applyStimulus(pl[i], 1'b1, pl[i] ? (N_CH'(1) << addr) : '0, addr, 1'b0, 1'b0, 1'b1);
`ifdef MSSD_PARITY_EN
        applyStimulus(par, 1'b0, '0, addr, 1'b0, 1'b0, 1'b1);
        if (par != evenPar(pl, len)) begin
            errd = 1'b1;
            return;
        end
`endif
        applyStimulus(stop, 1'b0, '0, addr, 1'b0, stop, 1'b1);
        errd = !stop;
    endtask

    // Hold the line low n cycles in ERR, then release it high.
    task automatic errRecover(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic        errd;
        logic [62:0] plB;
        logic [62:0] revB;
        int          v0;
        int          v1;
        int          dn;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_outs", 64'({outValid, Error, frame_done, busy, d, p}), 64'd0);
        rst   = 1'b1;
        chkEn = 1'b1;
        idleBits(3);

        // Basic frame: addr 2, len 5, payload 1,0,1,1,0.
        $display("[TB] basic frame");
        capCh = 2;
        v0 = validCnt[2];
        dn = doneCnt;
        sendFrame(2'd2, 5, 63'b01101, 1'b1, 1'b1, errd);
        idleBits(2);
        checkOutput("basic_valid_cycles", 64'(validCnt[2] - v0), 64'd5);
        checkOutput("basic_done_pulses", 64'(doneCnt - dn), 64'd1);
        checkOutput("basic_p2_seq", 64'(cap[4:0]), 64'b10110);

        // Zero-length frame on channel 3.
        $display("[TB] zero length");
        v0 = validCnt[0] + validCnt[1] + validCnt[2] + validCnt[3];
        dn = doneCnt;
        sendFrame(2'd3, 0, '0, 1'b0, 1'b1, errd);
        idleBits(2);
        checkOutput("zero_valid_cycles",
                    64'(validCnt[0] + validCnt[1] + validCnt[2] + validCnt[3] - v0), 64'd0);
        checkOutput("zero_done_pulses", 64'(doneCnt - dn), 64'd1);

        // Framing error: stop bit 0, then recovery and a good frame.
        $display("[TB] framing error");
        dn = doneCnt;
        sendFrame(2'd1, 2, 63'b11, 1'b0, 1'b0, errd);
        checkOutput("framing_err_expected", 64'(errd), 64'd1);
        errRecover(2);
        idleBits(1);
        capCh = 1;
        sendFrame(2'd1, 2, 63'b01, 1'b1, 1'b1, errd);
        idleBits(2);
        checkOutput("after_err_done", 64'(doneCnt - dn), 64'd1);
        checkOutput("after_err_p1_seq", 64'(cap[1:0]), 64'b10);

        // Back-to-back frames: addr 0 len 3, then addr 1 len 63.
        $display("[TB] back-to-back");
        plB = {$urandom, $urandom};
        plB[62] = 1'b1;
        for (int i = 0; i < 63; i++) revB[62-i] = plB[i];
        capCh = 1;
        v0 = validCnt[0];
        v1 = validCnt[1];
        dn = doneCnt;
        sendFrame(2'd0, 3, 63'b101, 1'b0, 1'b1, errd);
        sendFrame(2'd1, 63, plB, evenPar(plB, 63), 1'b1, errd);
        idleBits(2);
        checkOutput("b2b_ch0_cycles", 64'(validCnt[0] - v0), 64'd3);
        checkOutput("b2b_ch1_cycles", 64'(validCnt[1] - v1), 64'd63);
        checkOutput("b2b_done_pulses", 64'(doneCnt - dn), 64'd2);
        checkOutput("b2b_p1_seq", 64'(cap), 64'(revB));

        // Reset asserted on payload bit 3 of a 10-bit frame on channel 3.
        $display("[TB] reset mid-payload");
        begin
            logic [H-1:0] hb;
            hb = {CNT_W'(10), 2'd3};
            applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
            for (int i = 0; i < H; i++) applyStimulus(hb[i], 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
            applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
            for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 4'b1000, 2'd3, 1'b0, 1'b0, 1'b1);
        end
        applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        checkOutput("rst_async_outs", 64'({outValid, Error, frame_done, busy, d, p}), 64'd0);
        idleBits(2);
        #2;
        rst = 1'b1;
        idleBits(3);
        capCh = 3;
        dn = doneCnt;
        sendFrame(2'd3, 4, 63'b0110, 1'b0, 1'b1, errd);
        idleBits(2);
        checkOutput("post_rst_done", 64'(doneCnt - dn), 64'd1);
        checkOutput("post_rst_p3_seq", 64'(cap[3:0]), 64'b0110);

`ifdef MSSD_PARITY_EN
        // Parity: payload 1,1,1 needs parity bit 1.
        $display("[TB] parity");
        dn = doneCnt;
        sendFrame(2'd0, 3, 63'b111, 1'b1, 1'b1, errd);
        idleBits(2);
        checkOutput("parity_ok_done", 64'(doneCnt - dn), 64'd1);
        sendFrame(2'd0, 3, 63'b111, 1'b0, 1'b1, errd);
        checkOutput("parity_bad_err_expected", 64'(errd), 64'd1);
        errRecover(1);
        idleBits(2);
        checkOutput("parity_bad_no_done", 64'(doneCnt - dn), 64'd1);
`endif

        chkEn = 1'b0;
        @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
